// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths, FSM and owner encodings for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam int DataWidth  = 32;
  localparam int AddrWidth  = 32;
  localparam int Func3Width = 3;
  localparam int CntWidth   = 4;

  localparam logic [Func3Width-1:0] FUNC3_WORD = 3'b010;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// rtl/mem_port_arbiter_arb_pick.sv - combinational winner selection between fetch and load/store
// ARB_ROUND_ROBIN_EN: alternate on ties using last grant; otherwise LS beats IF.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic   i_if_req,
  input  logic   i_ls_req,
  input  owner_e i_last_grant,
  output logic   o_grant_valid,
  output owner_e o_grant_owner
);

  logic w_prefer_if;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_prefer_if = (i_last_grant == OWNER_LS);
`else
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
  assign w_prefer_if         = 1'b0;
`endif

  assign o_grant_valid = i_if_req | i_ls_req;

  // A lone requester always wins; w_prefer_if only breaks ties.
  always_comb begin
    o_grant_owner = OWNER_LS;
    if (i_if_req && (!i_ls_req || w_prefer_if)) begin
      o_grant_owner = OWNER_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one data memory between fetch and load/store with fixed latency
// Tie policy selected by ARB_ROUND_ROBIN_EN inside arb_pick.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W      = DataWidth,
  parameter int ADDR_W      = AddrWidth,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ready,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [Func3Width-1:0] ls_func3,
  output logic                  ls_ready,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [Func3Width-1:0] mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam logic [CntWidth-1:0] CNT_LOAD = CntWidth'(MEM_LATENCY - 1);

  arb_state_e            r_state;
  arb_state_e            w_next_state;
  logic [CntWidth-1:0]   r_cnt;
  owner_e                r_owner;
  owner_e                r_last_grant;
  logic                  r_is_store;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [Func3Width-1:0] r_mem_func3;
  logic [DATA_W-1:0]     r_if_rdata;
  logic [DATA_W-1:0]     r_ls_rdata;

  logic   w_grant_valid;
  owner_e w_grant_owner;
  logic   w_grant;
  logic   w_capture;
  logic   w_mem_we;
  logic   w_if_ready;
  logic   w_ls_ready;

  arb_pick u_arb_pick (
    .i_if_req      (if_req),
    .i_ls_req      (ls_req),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_owner (w_grant_owner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_capture    = 1'b0;
    w_mem_we     = 1'b0;
    w_if_ready   = 1'b0;
    w_ls_ready   = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_grant_valid) begin
          w_grant      = 1'b1;
          w_next_state = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        // Counter still holds its load value only in the first access cycle.
        w_mem_we = r_is_store && (r_cnt == CNT_LOAD);
        if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_next_state = ARB_RESP;
        end
      end
      ARB_RESP: begin
        w_if_ready   = (r_owner == OWNER_IF);
        w_ls_ready   = (r_owner == OWNER_LS);
        w_next_state = ARB_IDLE;
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_owner      <= OWNER_LS;
      r_last_grant <= OWNER_LS;
      r_is_store   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_func3  <= '0;
      r_if_rdata   <= '0;
      r_ls_rdata   <= '0;
    end else begin
      if (w_grant) begin
        r_owner      <= w_grant_owner;
        r_last_grant <= w_grant_owner;
        r_cnt        <= CNT_LOAD;
        if (w_grant_owner == OWNER_LS) begin
          r_mem_addr  <= ls_addr;
          r_mem_wdata <= ls_wdata;
          r_mem_func3 <= ls_func3;
          r_is_store  <= ls_we;
        end else begin
          r_mem_addr  <= if_addr;
          r_mem_func3 <= FUNC3_WORD;
          r_is_store  <= 1'b0;
        end
      end else if (r_state == ARB_ACCESS && r_cnt != '0) begin
        r_cnt <= r_cnt - CntWidth'(1);
      end
      if (w_capture && !r_is_store) begin
        if (r_owner == OWNER_LS) begin
          r_ls_rdata <= mem_rdata;
        end else begin
          r_if_rdata <= mem_rdata;
        end
      end
    end
  end

  // Gating with reset keeps a write or handshake from escaping in the reset cycle.
  assign mem_we    = w_mem_we & ~reset;
  assign if_ready  = w_if_ready & ~reset;
  assign ls_ready  = w_ls_ready & ~reset;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_func3 = r_mem_func3;
  assign if_rdata  = r_if_rdata;
  assign ls_rdata  = r_ls_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter (latency 1 and 3)
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [2:0]  ls_func3;
  logic        if_ready, ls_ready, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_func3;

  logic        b_if_req, b_ls_req, b_ls_we;
  logic [31:0] b_if_addr, b_ls_addr, b_ls_wdata;
  logic [2:0]  b_ls_func3;
  logic        b_if_ready, b_ls_ready, b_mem_we;
  logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [2:0]  b_mem_func3;

  logic [31:0] mem   [0:63];
  logic [31:0] mem_b [0:63];
  logic        pl_en, pl_b;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_func3(ls_func3), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ready(b_if_ready), .if_rdata(b_if_rdata),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
    .ls_func3(b_ls_func3), .ls_ready(b_ls_ready), .ls_rdata(b_ls_rdata),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata),
    .mem_func3(b_mem_func3), .mem_rdata(b_mem_rdata)
  );

  assign mem_rdata   = mem[mem_addr[7:2]];
  assign b_mem_rdata = mem_b[b_mem_addr[7:2]];

  always @(posedge clk) begin
    if (pl_en && !pl_b) mem[pl_idx] <= pl_data;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    if (pl_en && pl_b) mem_b[pl_idx] <= pl_data;
    else if (b_mem_we) mem_b[b_mem_addr[7:2]] <= b_mem_wdata;
  end

  task automatic poke(input logic sel_b, input int idx, input logic [31:0] d);
    pl_b = sel_b; pl_idx = idx[5:0]; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    if_req = 1'b1; ls_req = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready: got %0b want 0", if_ready); end
    n_tests++; if (ls_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ls_ready: got %0b want 0", ls_ready); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
    n_tests++; if (mem_func3 !== 3'b000) begin n_fail++; $display("FAIL reset_mem_func3: got %0b want 0", mem_func3); end
    n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %0h want 0", mem_wdata); end
    n_tests++; if (if_rdata !== 32'h0 || ls_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %0h/%0h want 0/0", if_rdata, ls_rdata); end
    if_req = 1'b0; ls_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (if_ready !== 1'b0 || ls_ready !== 1'b0) begin n_fail++; $display("FAIL reset_release_ready: got %0b%0b want 00", if_ready, ls_ready); end
  endtask

  task automatic test_if_fetch();
    if_addr = 32'h10; if_req = 1'b1;
    @(negedge clk);
    n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_early_ready: got %0b want 0", if_ready); end
    n_tests++; if (mem_func3 !== 3'b010) begin n_fail++; $display("FAIL fetch_func3: got %0b want 010", mem_func3); end
    n_tests++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL fetch_addr: got %0h want 10", mem_addr); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_mem_we: got %0b want 0", mem_we); end
    @(negedge clk);
    n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_ready: got %0b want 1", if_ready); end
    n_tests++; if (ls_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_ls_ready: got %0b want 0", ls_ready); end
    n_tests++; if (if_rdata !== 32'h00500093) begin n_fail++; $display("FAIL fetch_rdata: got %0h want 00500093", if_rdata); end
    if_req = 1'b0;
    @(negedge clk);
    n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_ready_width: got %0b want 0", if_ready); end
  endtask

  task automatic test_store_load();
    int we_cnt, rdy_at;
    ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'hDEADBEEF; ls_func3 = 3'b010; ls_req = 1'b1;
    we_cnt = 0; rdy_at = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_we === 1'b1) we_cnt++;
      if (ls_ready === 1'b1 && rdy_at == 0) begin rdy_at = c; ls_req = 1'b0; end
    end
    n_tests++; if (we_cnt != 1) begin n_fail++; $display("FAIL store_we_cycles: got %0d want 1", we_cnt); end
    n_tests++; if (rdy_at != 2) begin n_fail++; $display("FAIL store_ready_cycle: got %0d want 2", rdy_at); end
    n_tests++; if (mem[16] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_mem_word: got %0h want deadbeef", mem[16]); end
    n_tests++; if (ls_rdata !== 32'h0) begin n_fail++; $display("FAIL store_rdata_hold: got %0h want 0", ls_rdata); end
    ls_we = 1'b0; ls_wdata = 32'h0; ls_req = 1'b1;
    we_cnt = 0; rdy_at = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_we === 1'b1) we_cnt++;
      if (ls_ready === 1'b1 && rdy_at == 0) begin rdy_at = c; ls_req = 1'b0; end
    end
    n_tests++; if (we_cnt != 0) begin n_fail++; $display("FAIL load_we_cycles: got %0d want 0", we_cnt); end
    n_tests++; if (rdy_at != 2) begin n_fail++; $display("FAIL load_ready_cycle: got %0d want 2", rdy_at); end
    n_tests++; if (ls_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata: got %0h want deadbeef", ls_rdata); end
    n_tests++; if (if_rdata !== 32'h00500093) begin n_fail++; $display("FAIL load_if_rdata_hold: got %0h want 00500093", if_rdata); end
  endtask

  task automatic test_tie(input int round);
    int if_at, ls_at, both;
    int exp_if, exp_ls;
`ifdef ARB_ROUND_ROBIN_EN
    exp_if = 2; exp_ls = 5;
`else
    exp_if = 5; exp_ls = 2;
`endif
    if_addr = 32'h20; ls_addr = 32'h24; ls_we = 1'b0; ls_func3 = 3'b000;
    if_req = 1'b1; ls_req = 1'b1;
    if_at = 0; ls_at = 0; both = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (if_ready === 1'b1 && ls_ready === 1'b1) both++;
      if (if_ready === 1'b1 && if_at == 0) begin if_at = c; if_req = 1'b0; end
      if (ls_ready === 1'b1 && ls_at == 0) begin ls_at = c; ls_req = 1'b0; end
    end
    if_req = 1'b0; ls_req = 1'b0;
    n_tests++; if (if_at != exp_if) begin n_fail++; $display("FAIL tie%0d_if_cycle: got %0d want %0d", round, if_at, exp_if); end
    n_tests++; if (ls_at != exp_ls) begin n_fail++; $display("FAIL tie%0d_ls_cycle: got %0d want %0d", round, ls_at, exp_ls); end
    n_tests++; if (both != 0) begin n_fail++; $display("FAIL tie%0d_both_ready: got %0d want 0", round, both); end
    n_tests++; if (if_rdata !== 32'h11111111 || ls_rdata !== 32'h22222222) begin n_fail++; $display("FAIL tie%0d_rdata: got %0h/%0h want 11111111/22222222", round, if_rdata, ls_rdata); end
  endtask

  task automatic test_tie_held();
    int n, exp_at;
    logic exp_ls;
    if_addr = 32'h20; ls_addr = 32'h24; ls_we = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (if_ready === 1'b1 || ls_ready === 1'b1) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_ls = (n % 2 == 1);
`else
        exp_ls = 1'b1;
`endif
        exp_at = 2 + 3 * n;
        n_tests++; if (c != exp_at) begin n_fail++; $display("FAIL held_ready%0d_cycle: got %0d want %0d", n, c, exp_at); end
        n_tests++; if (ls_ready !== exp_ls || if_ready !== !exp_ls) begin n_fail++; $display("FAIL held_ready%0d_owner: got if=%0b ls=%0b want ls=%0b", n, if_ready, ls_ready, exp_ls); end
        n++;
        if (n == 3) begin if_req = 1'b0; ls_req = 1'b0; end
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    n_tests++; if (n != 3) begin n_fail++; $display("FAIL held_pulse_count: got %0d want 3", n); end
  endtask

  task automatic test_latency3();
    int rdy_at, rdy_cnt, we_cnt, we_first;
    b_ls_we = 1'b0; b_ls_addr = 32'h8; b_ls_func3 = 3'b010; b_ls_req = 1'b1;
    rdy_at = 0; rdy_cnt = 0; we_cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (b_mem_we === 1'b1) we_cnt++;
      if (b_ls_ready === 1'b1 || b_if_ready === 1'b1) rdy_cnt++;
      if (b_ls_ready === 1'b1 && rdy_at == 0) begin rdy_at = c; b_ls_req = 1'b0; end
    end
    n_tests++; if (rdy_at != 4) begin n_fail++; $display("FAIL lat3_load_cycle: got %0d want 4", rdy_at); end
    n_tests++; if (rdy_cnt != 1) begin n_fail++; $display("FAIL lat3_ready_count: got %0d want 1", rdy_cnt); end
    n_tests++; if (we_cnt != 0) begin n_fail++; $display("FAIL lat3_load_we: got %0d want 0", we_cnt); end
    n_tests++; if (b_ls_rdata !== 32'h33333333) begin n_fail++; $display("FAIL lat3_load_rdata: got %0h want 33333333", b_ls_rdata); end
    b_ls_we = 1'b1; b_ls_addr = 32'hC; b_ls_wdata = 32'h5A5A5A5A; b_ls_req = 1'b1;
    rdy_at = 0; we_cnt = 0; we_first = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (b_mem_we === 1'b1) begin we_cnt++; if (we_first == 0) we_first = c; end
      if (b_ls_ready === 1'b1 && rdy_at == 0) begin rdy_at = c; b_ls_req = 1'b0; end
    end
    n_tests++; if (we_cnt != 1 || we_first != 1) begin n_fail++; $display("FAIL lat3_store_we: got %0d cycles first %0d want 1 first 1", we_cnt, we_first); end
    n_tests++; if (rdy_at != 4) begin n_fail++; $display("FAIL lat3_store_cycle: got %0d want 4", rdy_at); end
    n_tests++; if (mem_b[3] !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL lat3_store_word: got %0h want 5a5a5a5a", mem_b[3]); end
    n_tests++; if (b_ls_rdata !== 32'h33333333) begin n_fail++; $display("FAIL lat3_store_rdata_hold: got %0h want 33333333", b_ls_rdata); end
  endtask

  task automatic test_back_to_back();
    int n, ls_bad;
    if_addr = 32'h0; if_req = 1'b1;
    n = 0; ls_bad = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (ls_ready === 1'b1) ls_bad++;
      if (if_ready === 1'b1) begin
        n_tests++; if (c != 2 + 3 * n) begin n_fail++; $display("FAIL b2b_ready%0d_cycle: got %0d want %0d", n, c, 2 + 3 * n); end
        n_tests++; if (if_rdata !== 32'hC0DE0000 + 32'(n)) begin n_fail++; $display("FAIL b2b_ready%0d_rdata: got %0h want %0h", n, if_rdata, 32'hC0DE0000 + 32'(n)); end
        n++;
        if (n == 3) if_req = 1'b0;
        else if_addr = 32'(4 * n);
      end
    end
    if_req = 1'b0;
    n_tests++; if (n != 3) begin n_fail++; $display("FAIL b2b_pulse_count: got %0d want 3", n); end
    n_tests++; if (ls_bad != 0) begin n_fail++; $display("FAIL b2b_ls_ready: got %0d want 0", ls_bad); end
  endtask

  task automatic test_reset_mid();
    ls_we = 1'b1; ls_addr = 32'h48; ls_wdata = 32'h12345678; ls_func3 = 3'b010; ls_req = 1'b1;
    @(negedge clk);
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_we: got %0b want 1", mem_we); end
    reset = 1'b1; ls_req = 1'b0;
    #1;
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_we: got %0b want 0", mem_we); end
    n_tests++; if (ls_ready !== 1'b0 || if_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %0b%0b want 00", if_ready, ls_ready); end
    @(negedge clk);
    reset = 1'b0;
    n_tests++; if (mem[18] !== 32'hAAAA0000) begin n_fail++; $display("FAIL rst_mid_mem_word: got %0h want aaaa0000", mem[18]); end
    n_tests++; if (mem_addr !== 32'h0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: got addr %0h we %0b want 0/0", mem_addr, mem_we); end
    n_tests++; if (ls_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata: got %0h want 0", ls_rdata); end
    repeat (3) begin
      @(negedge clk);
      n_tests++; if (ls_ready !== 1'b0 || if_ready !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after: got rdy %0b%0b we %0b want 000", if_ready, ls_ready, mem_we); end
    end
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_func3 = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_ls_req = 1'b0; b_ls_we = 1'b0; b_ls_addr = '0; b_ls_wdata = '0; b_ls_func3 = '0;
    pl_en = 1'b0; pl_b = 1'b0; pl_idx = '0; pl_data = '0;
    @(negedge clk);
    poke(1'b0, 4, 32'h00500093);
    poke(1'b0, 8, 32'h11111111);
    poke(1'b0, 9, 32'h22222222);
    poke(1'b0, 18, 32'hAAAA0000);
    for (int i = 0; i < 3; i++) poke(1'b0, i, 32'hC0DE0000 + 32'(i));
    poke(1'b1, 2, 32'h33333333);
    test_reset();
    test_if_fetch();
    test_store_load();
    test_tie(1);
    test_tie(2);
    test_tie_held();
    test_latency3();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
